xpb_lut_multi: RTL and testbench

//  Runtime-loadable, multi-lane table of precomputed reduction multiples
//  (xpb[i] = i*2^k*b mod M) for the modular squaring datapath.

---
 rtl/xpb_lut_multi_if.sv | 28 ++
 rtl/xpb_lut_multi.sv | 163 ++++++++++++++++
 tb/tb_xpb_lut_multi.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xpb_lut_multi_if.sv
// Load bus and multi-lane lookup bus of the xpb reduction-multiple table.
// master = table loader plus index source, slave = the table itself.
interface xpb_lut_multi_if #(
    parameter int IDX_BITS  = 5,
    parameter int WORD_BITS = 1024,
    parameter int SEG_BITS  = 64,
    parameter int NUM_LANES = 2
);
    logic                           ld_start;
    logic                           ld_valid;
    logic [SEG_BITS-1:0]            ld_data;
    logic                           ld_ready;
    logic                           in_valid;
    logic [NUM_LANES*IDX_BITS-1:0]  in_idx;
    logic                           out_valid;
    logic [NUM_LANES*WORD_BITS-1:0] out_data;
    logic                           lkp_err;

    modport master (
        output ld_start, ld_valid, ld_data, in_valid, in_idx,
        input  ld_ready, out_valid, out_data, lkp_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, in_valid, in_idx,
        output ld_ready, out_valid, out_data, lkp_err
    );
endinterface

// File: rtl/xpb_lut_multi.sv
// Runtime-loadable table of xpb reduction multiples, NUM_LANES lookups per cycle (XPB_LUT_ZERO_IDX_EN hardwires entry 0 to zero).
// Latency: 2 cycles from accepted in_valid to out_valid; load completes one cycle after the last segment.
// Backpressure: none; lookups are dropped with a lkp_err pulse while the table is not fully loaded.
module xpb_lut_multi #(
    parameter int IDX_BITS  = 5,
    parameter int WORD_BITS = 1024,
    parameter int SEG_BITS  = 64,
    parameter int NUM_LANES = 2
) (
    input  logic              clk,
    input  logic              rst,
    xpb_lut_multi_if.slave    lut
);
    localparam int DEPTH = 2**IDX_BITS;
    localparam int SEGS  = WORD_BITS / SEG_BITS;
    localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
`ifdef XPB_LUT_ZERO_IDX_EN
    localparam int BASE  = 1;
`else
    localparam int BASE  = 0;
`endif
    // Storage is segment-granular so each load beat is a plain single-word write.
    localparam int MEM_WORDS = (DEPTH - BASE) * SEGS;
    localparam int ADDR_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [SEG_W-1:0]    LAST_SEG = SEG_W'(SEGS - 1);
    localparam logic [IDX_BITS-1:0] LAST_ENT = IDX_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_READY
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [SEG_W-1:0]               r_seg;
    logic [SEG_W-1:0]               w_seg_nxt;
    logic [IDX_BITS-1:0]            r_ent;
    logic [IDX_BITS-1:0]            w_ent_nxt;
    logic                           w_seg_acc;
    logic                           w_wr_en;
    logic [ADDR_W-1:0]              w_wr_addr;
    logic                           w_ready;
    logic                           w_lkp_acc;

    logic [SEG_BITS-1:0]            r_mem [MEM_WORDS];

    logic                           r_idx_vld;
    logic [NUM_LANES*IDX_BITS-1:0]  r_idx;
    logic                           r_out_vld;
    logic [NUM_LANES*WORD_BITS-1:0] r_out_dat;
    logic [NUM_LANES*WORD_BITS-1:0] w_rd_dat;
    logic                           r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_seg   <= '0;
            r_ent   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
            r_ent   <= w_ent_nxt;
        end
    end

    // ld_start has priority over ld_valid so a colliding segment is discarded.
    always_comb begin
        w_state_nxt = r_state;
        w_seg_nxt   = r_seg;
        w_ent_nxt   = r_ent;
        w_seg_acc   = 1'b0;
        case (r_state)
            ST_EMPTY, ST_READY: begin
                if (lut.ld_start) begin
                    w_state_nxt = ST_LOAD;
                    w_seg_nxt   = '0;
                    w_ent_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (lut.ld_start) begin
                    w_seg_nxt = '0;
                    w_ent_nxt = '0;
                end else if (lut.ld_valid) begin
                    w_seg_acc = 1'b1;
                    if (r_seg == LAST_SEG) begin
                        w_seg_nxt = '0;
                        if (r_ent == LAST_ENT) begin
                            w_ent_nxt   = '0;
                            w_state_nxt = ST_READY;
                        end else begin
                            w_ent_nxt = r_ent + 1'b1;
                        end
                    end else begin
                        w_seg_nxt = r_seg + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

`ifdef XPB_LUT_ZERO_IDX_EN
    assign w_wr_en = w_seg_acc && (r_ent != '0);
`else
    assign w_wr_en = w_seg_acc;
`endif
    assign w_wr_addr = ADDR_W'((int'(r_ent) - BASE) * SEGS + int'(r_seg));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= lut.ld_data;
        end
    end

    assign w_ready   = (r_state == ST_READY);
    assign w_lkp_acc = lut.in_valid && w_ready;

    always_comb begin
        w_rd_dat = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < SEGS; s++) begin
`ifdef XPB_LUT_ZERO_IDX_EN
                if (r_idx[l*IDX_BITS +: IDX_BITS] != '0) begin
                    w_rd_dat[(l*SEGS+s)*SEG_BITS +: SEG_BITS] =
                        r_mem[ADDR_W'((int'(r_idx[l*IDX_BITS +: IDX_BITS]) - BASE) * SEGS + s)];
                end
`else
                w_rd_dat[(l*SEGS+s)*SEG_BITS +: SEG_BITS] =
                    r_mem[ADDR_W'((int'(r_idx[l*IDX_BITS +: IDX_BITS]) - BASE) * SEGS + s)];
`endif
            end
        end
    end

    // Stage 1 captures indices, stage 2 captures table data; out_data holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_vld <= 1'b0;
            r_idx     <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_err     <= 1'b0;
        end else begin
            r_idx_vld <= w_lkp_acc;
            if (w_lkp_acc) begin
                r_idx <= lut.in_idx;
            end
            r_out_vld <= r_idx_vld;
            if (r_idx_vld) begin
                r_out_dat <= w_rd_dat;
            end
            r_err <= lut.in_valid && !w_ready;
        end
    end

    assign lut.ld_ready  = w_ready;
    assign lut.out_valid = r_out_vld;
    assign lut.out_data  = r_out_dat;
    assign lut.lkp_err   = r_err;
endmodule

// File: tb/tb_xpb_lut_multi.sv
// Bench for xpb_lut_multi: randomized loads and lookups checked every cycle against a table/queue model.
// Latency: model expects out_valid two edges after an accepted request.
// Backpressure: none in the DUT; bench drives requests freely and expects lkp_err when not loaded.
module tb_xpb_lut_multi;
    localparam int IDX_BITS  = 5;
    localparam int WORD_BITS = 1024;
    localparam int SEG_BITS  = 64;
    localparam int NUM_LANES = 2;
    localparam int DEPTH     = 2**IDX_BITS;
    localparam int SEGS      = WORD_BITS / SEG_BITS;
    localparam int TOTAL     = DEPTH * SEGS;
    localparam int IW        = NUM_LANES * IDX_BITS;
    localparam int OW        = NUM_LANES * WORD_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xpb_lut_multi_if #(.IDX_BITS(IDX_BITS), .WORD_BITS(WORD_BITS),
                       .SEG_BITS(SEG_BITS), .NUM_LANES(NUM_LANES)) lut();

    xpb_lut_multi #(.IDX_BITS(IDX_BITS), .WORD_BITS(WORD_BITS),
                    .SEG_BITS(SEG_BITS), .NUM_LANES(NUM_LANES)) dut (
        .clk (clk),
        .rst (rst),
        .lut (lut)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int vld_seen = 0;

    // Reference model: the table as words, a load counter, and a two-deep request pipeline.
    logic [WORD_BITS-1:0] m_tab [DEPTH];
    bit                   m_ready;
    bit                   m_loading;
    int                   m_cnt;
    bit                   p1_vld;
    logic [OW-1:0]        p1_dat;
    bit                   e_vld;
    bit                   e_err;
    logic [OW-1:0]        e_dat;
    bit                   mon_on = 1'b0;

    function automatic logic [OW-1:0] m_lookup(input logic [IW-1:0] idx);
        logic [OW-1:0] r;
        int e;
        r = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            e = int'(idx[l*IDX_BITS +: IDX_BITS]);
`ifdef XPB_LUT_ZERO_IDX_EN
            if (e != 0) r[l*WORD_BITS +: WORD_BITS] = m_tab[e];
`else
            r[l*WORD_BITS +: WORD_BITS] = m_tab[e];
`endif
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready   = 1'b0;
            m_loading = 1'b0;
            m_cnt     = 0;
            p1_vld    = 1'b0;
            e_vld     = 1'b0;
            e_err     = 1'b0;
            e_dat     = '0;
            mon_on    = 1'b1;
        end else begin
            e_vld = p1_vld;
            if (p1_vld) e_dat = p1_dat;
            e_err  = lut.in_valid && !m_ready;
            p1_vld = lut.in_valid && m_ready;
            if (p1_vld) p1_dat = m_lookup(lut.in_idx);
            if (lut.ld_start) begin
                m_loading = 1'b1;
                m_cnt     = 0;
                m_ready   = 1'b0;
            end else if (m_loading && lut.ld_valid) begin
                m_tab[m_cnt / SEGS][(m_cnt % SEGS)*SEG_BITS +: SEG_BITS] = lut.ld_data;
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_loading = 1'b0;
                    m_cnt     = 0;
                    m_ready   = 1'b1;
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [WORD_BITS-1:0] got, input logic [WORD_BITS-1:0] exp);
        int fs;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            fs = 0;
            for (int s = SEGS - 1; s >= 0; s--)
                if (got[s*SEG_BITS +: SEG_BITS] !== exp[s*SEG_BITS +: SEG_BITS]) fs = s;
            $display("FAIL %s: seg %0d got %h want %h at %0t", nm, fs,
                     got[fs*SEG_BITS +: SEG_BITS], exp[fs*SEG_BITS +: SEG_BITS], $time);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk1("out_valid", lut.out_valid, e_vld);
            chk1("lkp_err", lut.lkp_err, e_err);
            chk1("ld_ready", lut.ld_ready, m_ready);
            for (int l = 0; l < NUM_LANES; l++)
                chkw($sformatf("out_data lane%0d", l), lut.out_data[l*WORD_BITS +: WORD_BITS],
                     e_dat[l*WORD_BITS +: WORD_BITS]);
            if (lut.out_valid) vld_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SEG_BITS-1:0] seg_val(input int mode, input int e);
        case (mode)
            0:       return 64'(e) * 64'h0101;
            2:       return (e == 0) ? '1 : 64'(e) * 64'h0101;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic load_table(input int mode, input bit gaps, input int abort_at);
        int  n;
        bit  aborted;
        lut.ld_start = 1'b1;
        lut.ld_valid = 1'b0;
        tick();
        lut.ld_start = 1'b0;
        lut.in_valid = 1'b0;
        chk1("ld_ready drop after ld_start", lut.ld_ready, 1'b0);
        aborted = 1'b0;
        n = 0;
        while (n < TOTAL) begin
            if (gaps) begin
                while ($urandom % 4 == 0) begin
                    lut.ld_valid = 1'b0;
                    lut.in_valid = ($urandom % 2) != 0;
                    lut.in_idx   = IW'($urandom);
                    tick();
                end
            end
            lut.in_valid = gaps ? (($urandom % 2) != 0) : 1'b0;
            lut.in_idx   = IW'($urandom);
            if (n == abort_at && !aborted) begin
                lut.ld_start = 1'b1;
                lut.ld_valid = 1'b1;
                lut.ld_data  = {$urandom, $urandom};
                tick();
                lut.ld_start = 1'b0;
                aborted = 1'b1;
                n = 0;
            end else begin
                if (n == TOTAL - 1) chk1("ld_ready before last seg", lut.ld_ready, 1'b0);
                lut.ld_valid = 1'b1;
                lut.ld_data  = seg_val(mode, n / SEGS);
                tick();
                n++;
            end
        end
        lut.ld_valid = 1'b0;
        lut.in_valid = 1'b0;
        chk1("ld_ready after last seg", lut.ld_ready, 1'b1);
    endtask

    task automatic rand_lookups(input int n);
        for (int i = 0; i < n; i++) begin
            lut.in_valid = ($urandom % 4) != 0;
            lut.in_idx   = IW'($urandom);
            lut.ld_valid = ($urandom % 8) == 0;
            lut.ld_data  = {$urandom, $urandom};
            tick();
        end
        lut.in_valid = 1'b0;
        lut.ld_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    logic [WORD_BITS-1:0] lit;
    int                   vld0;

    initial begin
        rst          = 1'b1;
        lut.ld_start = 1'b0;
        lut.ld_valid = 1'b0;
        lut.ld_data  = '0;
        lut.in_valid = 1'b0;
        lut.in_idx   = '0;

        // T1 reset
        tick();
        tick();
        chk1("T1 ld_ready", lut.ld_ready, 1'b0);
        chk1("T1 out_valid", lut.out_valid, 1'b0);
        lit = '0;
        chkw("T1 out_data lane0", lut.out_data[0 +: WORD_BITS], lit);
        chkw("T1 out_data lane1", lut.out_data[WORD_BITS +: WORD_BITS], lit);
        rst          = 1'b0;
        lut.in_valid = 1'b1;
        lut.in_idx   = IW'($urandom);
        tick();
        lut.in_valid = 1'b0;
        chk1("T1 lkp_err pulse", lut.lkp_err, 1'b1);
        tick();
        chk1("T1 lkp_err one cycle", lut.lkp_err, 1'b0);
        chk1("T1 no out_valid", lut.out_valid, 1'b0);

        // T2 pattern load, lanes (3,31)
        load_table(0, 1'b0, -1);
        lut.in_valid = 1'b1;
        lut.in_idx   = {5'd31, 5'd3};
        tick();
        lut.in_valid = 1'b0;
        chk1("T2 out_valid after 1", lut.out_valid, 1'b0);
        tick();
        chk1("T2 out_valid after 2", lut.out_valid, 1'b1);
        lit = {SEGS{64'h0000_0000_0000_0303}};
        chkw("T2 lane0 idx3", lut.out_data[0 +: WORD_BITS], lit);
        lit = {SEGS{64'h0000_0000_0000_1F1F}};
        chkw("T2 lane1 idx31", lut.out_data[WORD_BITS +: WORD_BITS], lit);
        tick();

        // T3 back-to-back streaming
        vld0 = vld_seen;
        for (int i = 0; i < 32; i++) begin
            lut.in_valid = 1'b1;
            lut.in_idx   = {5'(31 - i), 5'(i)};
            tick();
        end
        lut.in_valid = 1'b0;
        tick();
        tick();
        chk_int("T3 out_valid count", vld_seen - vld0, 32);

        // T4 random table, reload with lookups in flight
        load_table(1, 1'b1, -1);
        rand_lookups(40);
        lut.in_valid = 1'b1;
        lut.in_idx   = IW'($urandom);
        tick();
        lut.in_idx   = IW'($urandom);
        load_table(1, 1'b1, -1);
        rand_lookups(200);

        // T5 restart collision after 100 segments
        load_table(1, 1'b0, 100);
        rand_lookups(100);

        // T6 zero entry
        load_table(2, 1'b0, -1);
        lut.in_valid = 1'b1;
        lut.in_idx   = '0;
        tick();
        lut.in_valid = 1'b0;
        tick();
`ifdef XPB_LUT_ZERO_IDX_EN
        lit = '0;
`else
        lit = '1;
`endif
        chkw("T6 lane0 idx0", lut.out_data[0 +: WORD_BITS], lit);
        chkw("T6 lane1 idx0", lut.out_data[WORD_BITS +: WORD_BITS], lit);
        rand_lookups(100);

        // T7 reset mid-lookup and mid-load
        lut.in_valid = 1'b1;
        lut.in_idx   = IW'($urandom);
        tick();
        lut.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("T7 flushed out_valid", lut.out_valid, 1'b0);
        chk1("T7 ld_ready after rst", lut.ld_ready, 1'b0);
        lut.ld_start = 1'b1;
        tick();
        lut.ld_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            lut.ld_valid = 1'b1;
            lut.ld_data  = {$urandom, $urandom};
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lut.ld_valid = 1'b1;
            lut.ld_data  = {$urandom, $urandom};
            lut.in_valid = 1'b1;
            tick();
        end
        lut.ld_valid = 1'b0;
        lut.in_valid = 1'b0;
        chk1("T7 still empty", lut.ld_ready, 1'b0);
        load_table(1, 1'b1, -1);
        rand_lookups(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
